// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit pipelined processor: word widths, NOP encoding,
// fetch FSM states and the IF/ID bundle exchanged between fetch and decode.
package cpu_pkg;

    localparam int unsigned WORD_W = 16;
    localparam int unsigned ADDR_W = 16;

    localparam logic [WORD_W-1:0] NOP_INSTR = 16'h0000;
    localparam logic [ADDR_W-1:0] RESET_PC  = 16'h0000;

    // Bit of the first instruction word that announces a trailing immediate word
    localparam int unsigned IMM_BIT = 0;

    typedef enum logic [0:0] {
        S_FETCH = 1'b0,
        S_IMM   = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [WORD_W-1:0] instruction;
        logic [WORD_W-1:0] immediate;
        logic [ADDR_W-1:0] pc;
        logic              valid;
    } if_id_t;

    // Squashed IF/ID entry; pc is carried over so pc_out keeps its last value
    function automatic if_id_t make_bubble(input logic [ADDR_W-1:0] keep_pc);
        if_id_t b;
        b.instruction = NOP_INSTR;
        b.immediate   = '0;
        b.pc          = keep_pc;
        b.valid       = 1'b0;
        return b;
    endfunction

endpackage

// File: rtl/pc_register.sv
// Program counter: synchronous reset, absolute load, hold, otherwise +1 with wrap.
module pc_register
    import cpu_pkg::*;
#(
    parameter int unsigned            ADDR_WIDTH = ADDR_W,
    parameter logic [ADDR_WIDTH-1:0]  RESET_PC   = cpu_pkg::RESET_PC
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [ADDR_WIDTH-1:0] target,
    input  logic                  hold,
    output logic [ADDR_WIDTH-1:0] pc
);

    localparam logic [ADDR_WIDTH-1:0] PC_STEP = 1;

    // PC update: reset > load > hold > increment (modulo 2^ADDR_WIDTH)
    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (load) begin
            pc <= target;
        end else if (!hold) begin
            pc <= pc + PC_STEP;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch front end: drives imem_addr from the PC, assembles one- and
// two-word instructions and loads them into the IF/ID register for decode.
// The IF/ID bundle uses the package word widths, so WIDTH/ADDR_WIDTH are expected
// to stay at their package defaults.
module fetch_stage
    import cpu_pkg::*;
#(
    parameter int unsigned            WIDTH      = WORD_W,
    parameter int unsigned            ADDR_WIDTH = ADDR_W,
    parameter logic [ADDR_WIDTH-1:0]  RESET_PC   = cpu_pkg::RESET_PC,
    parameter int unsigned            IMM_BIT    = cpu_pkg::IMM_BIT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  branch_taken,
    input  logic [ADDR_WIDTH-1:0] branch_target,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic [WIDTH-1:0]      imem_data,
    output logic [WIDTH-1:0]      instruction,
    output logic [WIDTH-1:0]      immediate,
    output logic [ADDR_WIDTH-1:0] pc_out,
    output logic                  valid
);

    logic [ADDR_WIDTH-1:0] pc;
    fetch_state_t          state;
    fetch_state_t          state_next;
    logic [WIDTH-1:0]      hold_instr;
    logic [ADDR_WIDTH-1:0] hold_pc;
    if_id_t                if_id;
    if_id_t                if_id_next;

    logic                  pc_load;
    logic                  pc_hold;
    logic [ADDR_WIDTH-1:0] pc_target;
    logic                  hold_capture;
    logic                  has_imm;
    logic                  squash;

    assign has_imm   = imem_data[IMM_BIT];
    // A taken branch implies a flush of the IF/ID contents
    assign squash    = branch_taken | flush;
    assign imem_addr = pc;

    pc_register #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .RESET_PC   (RESET_PC)
    ) u_pc_register (
        .clk    (clk),
        .rst    (rst),
        .load   (pc_load),
        .target (pc_target),
        .hold   (pc_hold),
        .pc     (pc)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_FETCH;
        end else begin
            state <= state_next;
        end
    end

    // FSM next state: squash abandons any partial two-word fetch, stall freezes
    always_comb begin
        state_next = state;
        if (squash) begin
            state_next = S_FETCH;
        end else if (!stall) begin
            case (state)
                S_FETCH: state_next = has_imm ? S_IMM : S_FETCH;
                S_IMM:   state_next = S_FETCH;
                default: state_next = S_FETCH;
            endcase
        end
    end

    // FSM outputs: PC control, first-word capture and the next IF/ID entry
    always_comb begin
        // Flush in S_IMM rewinds to the first word so the pair is refetched whole
        pc_load      = branch_taken | (flush & (state == S_IMM));
        pc_target    = branch_taken ? branch_target : hold_pc;
        pc_hold      = ~pc_load & (flush | stall);
        hold_capture = 1'b0;
        if_id_next   = if_id;

        if (squash) begin
            if_id_next = make_bubble(if_id.pc);
        end else if (!stall) begin
            case (state)
                S_FETCH: begin
                    if (has_imm) begin
                        hold_capture = 1'b1;
                        if_id_next   = make_bubble(if_id.pc);
                    end else begin
                        if_id_next.instruction = imem_data;
                        if_id_next.immediate   = '0;
                        if_id_next.pc          = pc;
                        if_id_next.valid       = 1'b1;
                    end
                end
                S_IMM: begin
                    if_id_next.instruction = hold_instr;
                    if_id_next.immediate   = imem_data;
                    if_id_next.pc          = hold_pc;
                    if_id_next.valid       = 1'b1;
                end
                default: if_id_next = make_bubble(if_id.pc);
            endcase
        end
    end

    // First word and its address of a two-word instruction in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_instr <= NOP_INSTR;
            hold_pc    <= RESET_PC;
        end else if (hold_capture) begin
            hold_instr <= imem_data;
            hold_pc    <= pc;
        end
    end

    // IF/ID pipeline register
    always_ff @(posedge clk) begin
        if (rst) begin
            if_id.instruction <= NOP_INSTR;
            if_id.immediate   <= '0;
            if_id.pc          <= RESET_PC;
            if_id.valid       <= 1'b0;
        end else begin
            if_id <= if_id_next;
        end
    end

    assign instruction = if_id.instruction;
    assign immediate   = if_id.immediate;
    assign pc_out      = if_id.pc;
    assign valid       = if_id.valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Table-driven bench for fetch_stage: each vector gives the control inputs for one
// rising edge and the IF/ID outputs and imem_addr expected just after that edge.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        flush;
    logic        branch_taken;
    logic [15:0] branch_target;
    logic [15:0] imem_addr;
    logic [15:0] imem_data;
    logic [15:0] instruction;
    logic [15:0] immediate;
    logic [15:0] pc_out;
    logic        valid;

    logic [15:0] mem [0:65535];

    int n_vec = 0;
    int n_miss = 0;

    typedef struct {
        logic        rst;
        logic        stall;
        logic        flush;
        logic        br;
        logic [15:0] tgt;
        logic [15:0] e_instr;
        logic [15:0] e_imm;
        logic [15:0] e_pc;
        logic        e_valid;
        logic [15:0] e_addr;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    assign imem_data = mem[imem_addr];

    fetch_stage dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .flush         (flush),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem_addr     (imem_addr),
        .imem_data     (imem_data),
        .instruction   (instruction),
        .immediate     (immediate),
        .pc_out        (pc_out),
        .valid         (valid)
    );

    task automatic check(input int idx, input string tag, input logic [15:0] got,
                         input logic [15:0] want);
        if (got !== want) begin
            n_miss++;
            $display("FAIL step %0d %s: got %h, want %h", idx, tag, got, want);
        end
    endtask

    // Drive one edge's inputs, let the edge pass, then compare all observed outputs
    task automatic apply(input int idx, input vec_t v);
        rst           = v.rst;
        stall         = v.stall;
        flush         = v.flush;
        branch_taken  = v.br;
        branch_target = v.tgt;
        @(posedge clk);
        #1;
        n_vec++;
        check(idx, "instruction", instruction, v.e_instr);
        check(idx, "immediate", immediate, v.e_imm);
        check(idx, "pc_out", pc_out, v.e_pc);
        check(idx, "valid", {15'd0, valid}, {15'd0, v.e_valid});
        check(idx, "imem_addr", imem_addr, v.e_addr);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; flush = 1'b0; branch_taken = 1'b0; branch_target = '0;

        for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
        mem[16'h0000] = 16'h1000;  mem[16'h0001] = 16'h2000;  mem[16'h0002] = 16'h3000;
        mem[16'h0003] = 16'h4001;  mem[16'h0004] = 16'h00AB;  mem[16'h0005] = 16'h5000;
        mem[16'h0006] = 16'h6000;  mem[16'h0007] = 16'h7000;
        mem[16'h0010] = 16'hC001;  mem[16'h0011] = 16'h1234;  mem[16'h0012] = 16'hD000;
        mem[16'h0013] = 16'hF001;  mem[16'h0014] = 16'h5555;
        mem[16'h0040] = 16'hA000;  mem[16'h0041] = 16'hB000;
        mem[16'hFFFE] = 16'h9000;  mem[16'hFFFF] = 16'hE001;

        //                rst   stl   fl    br    tgt       instr     imm       pc_out    v     addr
        // reset and one-word stream
        vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'h0000});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h1000, 16'h0000, 16'h0000, 1'b1, 16'h0001});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h2000, 16'h0000, 16'h0001, 1'b1, 16'h0002});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h3000, 16'h0000, 16'h0002, 1'b1, 16'h0003});
        // two-word at 3: bubble then assembled pair
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0002, 1'b0, 16'h0004});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h4001, 16'h00AB, 16'h0003, 1'b1, 16'h0005});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h5000, 16'h0000, 16'h0005, 1'b1, 16'h0006});
        // three-cycle stall, then resume with 6
        vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h5000, 16'h0000, 16'h0005, 1'b1, 16'h0006});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h5000, 16'h0000, 16'h0005, 1'b1, 16'h0006});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h5000, 16'h0000, 16'h0005, 1'b1, 16'h0006});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h6000, 16'h0000, 16'h0006, 1'b1, 16'h0007});
        // branch with simultaneous stall: branch wins
        vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b1, 16'h0040, 16'h0000, 16'h0000, 16'h0006, 1'b0, 16'h0040});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'hA000, 16'h0000, 16'h0040, 1'b1, 16'h0041});
        // branch to two-word at 0x10, flush in S_IMM, refetch
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 16'h0010, 16'h0000, 16'h0000, 16'h0040, 1'b0, 16'h0010});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0040, 1'b0, 16'h0011});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0040, 1'b0, 16'h0010});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0040, 1'b0, 16'h0011});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'hC001, 16'h1234, 16'h0010, 1'b1, 16'h0012});
        // flush in S_FETCH: pc holds
        vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0010, 1'b0, 16'h0012});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'hD000, 16'h0000, 16'h0012, 1'b1, 16'h0013});
        // stall while in S_IMM keeps the bubble
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0012, 1'b0, 16'h0014});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0012, 1'b0, 16'h0014});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'hF001, 16'h5555, 16'h0013, 1'b1, 16'h0015});
        // wrap: 0xFFFE one-word, 0xFFFF two-word taking immediate from address 0
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 16'hFFFE, 16'h0000, 16'h0000, 16'h0013, 1'b0, 16'hFFFE});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h9000, 16'h0000, 16'hFFFE, 1'b1, 16'hFFFF});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'hFFFE, 1'b0, 16'h0000});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'hE001, 16'h1000, 16'hFFFF, 1'b1, 16'h0001});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h2000, 16'h0000, 16'h0001, 1'b1, 16'h0002});
        // reset beats a simultaneous branch
        vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 16'h0005, 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'h0000});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h1000, 16'h0000, 16'h0000, 1'b1, 16'h0001});

        foreach (vecs[i]) apply(i, vecs[i]);

        // Hand sequence: flush and stall together in S_IMM -> flush wins, pair refetched
        apply(100, '{1'b0, 1'b0, 1'b0, 1'b1, 16'h0010, 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'h0010});
        apply(101, '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'h0011});
        apply(102, '{1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'h0010});
        apply(103, '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'h0011});
        apply(104, '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'hC001, 16'h1234, 16'h0010, 1'b1, 16'h0012});

        // Hand sequence: branch in S_IMM abandons the pair and goes straight to the target
        apply(110, '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'hD000, 16'h0000, 16'h0012, 1'b1, 16'h0013});
        apply(111, '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0012, 1'b0, 16'h0014});
        apply(112, '{1'b0, 1'b0, 1'b0, 1'b1, 16'h0040, 16'h0000, 16'h0000, 16'h0012, 1'b0, 16'h0040});
        apply(113, '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'hA000, 16'h0000, 16'h0040, 1'b1, 16'h0041});
        apply(114, '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'hB000, 16'h0000, 16'h0041, 1'b1, 16'h0042});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
